// File: rtl/radio_timing_engine.sv
// radio_timing_engine: sequences one radio receive window (warm-up, RX, guard) from registered outputs
// Ports: ck/rst (sync, active-high), start, abort, rx_len[CNT_W] in;
//        radioEnable, radioRxEn, busy, done out; isolate in only when TE_ISOLATE_EN is defined.
// Parameters: CNT_W, WARMUP_CYC, GUARD_CYC. Optional feature macro: TE_ISOLATE_EN.
module radio_timing_engine #(
    parameter int CNT_W      = 16,
    parameter int WARMUP_CYC = 8,
    parameter int GUARD_CYC  = 4
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] rx_len,
`ifdef TE_ISOLATE_EN
    input  logic             isolate,
`endif
    output logic             radioEnable,
    output logic             radioRxEn,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, WARMUP, RX, GUARD} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;
    logic en_q, en_d, rx_q, rx_d, busy_q, busy_d, done_q, done_d;
    logic iso;
`ifdef TE_ISOLATE_EN
    assign iso = isolate;
`else
    assign iso = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        done_d  = 1'b0;
        // hold at zero so the counter never wraps
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        case (state_q)
            IDLE: if (start && !abort) begin
                state_d = WARMUP;
                len_d   = rx_len;
                cnt_d   = CNT_W'(WARMUP_CYC - 1);
            end
            WARMUP: if (abort || (cnt_q == '0 && len_q == '0)) begin
                state_d = GUARD;
                cnt_d   = CNT_W'(GUARD_CYC - 1);
            end else if (cnt_q == '0) begin
                state_d = RX;
                cnt_d   = len_q - CNT_W'(1);
            end
            RX: if (abort || cnt_q == '0) begin
                state_d = GUARD;
                cnt_d   = CNT_W'(GUARD_CYC - 1);
            end
            default: if (cnt_q == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        endcase
        // isolation drops the window at once: no guard, no done
        if (iso) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
        end
        // outputs decoded from the next state so they leave the flops aligned with the state
        en_d   = state_d != IDLE;
        rx_d   = state_d == RX;
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            en_q    <= 1'b0;
            rx_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            en_q    <= en_d;
            rx_q    <= rx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign radioEnable = en_q & ~iso;
    assign radioRxEn   = rx_q & ~iso;
    assign done        = done_q & ~iso;
    assign busy        = busy_q;
endmodule

// File: tb/tb_radio_timing_engine.sv
// tb_radio_timing_engine: directed bench with a timestamp-based window model for radio_timing_engine
module tb_radio_timing_engine;
    localparam int W = 8;
    localparam int G = 4;
    logic ck = 1'b0;
    logic rst = 1'b1, start = 1'b0, abort = 1'b0, iso_in = 1'b0;
    logic [15:0] rx_len = '0;
    logic radioEnable, radioRxEn, busy, done;
    int tests = 0, fails = 0;
    radio_timing_engine #(.CNT_W(16), .WARMUP_CYC(W), .GUARD_CYC(G)) dut (
        .ck(ck), .rst(rst), .start(start), .abort(abort), .rx_len(rx_len),
`ifdef TE_ISOLATE_EN
        .isolate(iso_in),
`endif
        .radioEnable(radioEnable), .radioRxEn(radioRxEn), .busy(busy), .done(done)
    );
    always #5 ck = ~ck;
    // Window model: each window is a set of cycle timestamps (cycle n = interval after edge n)
    int n = 0;
    bit act = 1'b0;
    int e0, rxs, rxe, ene;
    function automatic bit m_en(int c);
        return act && c >= e0 && c < ene;
    endfunction
    always @(posedge ck) begin
        n++;
        if (rst || iso_in) act = 1'b0;
        else if (!m_en(n - 1) && start && !abort) begin
            act = 1'b1; e0 = n; rxs = n + W; rxe = rxs + int'(rx_len); ene = rxe + G;
        end else if (abort && act && n - 1 >= e0 && n - 1 < rxe) begin
            if (n < rxs) rxs = n;
            rxe = n; ene = n + G;
        end
    end
    task automatic check(string nm, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, n, got, exp);
        end
    endtask
    bit chk = 1'b0;
    int n_en = 0, n_rx = 0, n_done = 0, en_rise = 0, rx_rise = 0;
    logic p_en = 1'b0, p_rx = 1'b0;
    initial forever begin
        @(negedge ck);
        #2;
        if (chk) begin
            check("radioEnable", int'(radioEnable), int'(m_en(n) && !iso_in));
            check("radioRxEn", int'(radioRxEn), int'(act && n >= rxs && n < rxe && !iso_in));
            check("busy", int'(busy), int'(m_en(n)));
            check("done", int'(done), int'(act && n == ene && !iso_in));
            check("order", int'(radioRxEn && !radioEnable), 0);
            if (radioEnable) n_en++;
            if (radioRxEn) n_rx++;
            if (done) n_done++;
            if (radioEnable && !p_en) en_rise = n;
            if (radioRxEn && !p_rx) rx_rise = n;
            p_en = radioEnable;
            p_rx = radioRxEn;
        end
    end
    task automatic step(int k);
        repeat (k) @(negedge ck);
    endtask
    // Pulse start for one edge; leaves us at the negedge inside cycle e0.
    task automatic kick(int len);
        rx_len = 16'(len); start = 1'b1;
        step(1);
        start = 1'b0;
    endtask
    int b_en, b_rx, b_done;
    task automatic snap();
        b_en = n_en; b_rx = n_rx; b_done = n_done;
    endtask
    task automatic expect_counts(string nm, int en, int rx, int dn);
        check({nm, " en cycles"}, n_en - b_en, en);
        check({nm, " rx cycles"}, n_rx - b_rx, rx);
        check({nm, " done pulses"}, n_done - b_done, dn);
    endtask
    initial begin
        step(1);
        rst = 1'b1;
        step(3);
        chk = 1'b1;
        rst = 1'b0;
        snap();
        step(4);
        expect_counts("T1", 0, 0, 0);
        snap();
        kick(10);
        step(28);
        expect_counts("T2", 22, 10, 1);
        check("T2 rx offset", rx_rise - en_rise, 8);
        snap();
        kick(0);
        step(18);
        expect_counts("T3", 12, 0, 1);
        snap();
        kick(10);
        step(4);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(5);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(10);
        expect_counts("T4", 15, 3, 1);
        snap();
        kick(10);
        step(12);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(4);
        expect_counts("T5", 13, 5, 0);
        snap();
        kick(10);
        step(28);
        expect_counts("T5 rerun", 22, 10, 1);
        check("T5 rx offset", rx_rise - en_rise, 8);
`ifdef TE_ISOLATE_EN
        snap();
        kick(10);
        step(12);
        iso_in = 1'b1;
        start = 1'b1;
        step(2);
        iso_in = 1'b0;
        start = 1'b0;
        step(6);
        expect_counts("T6", 12, 4, 0);
        snap();
        kick(10);
        step(28);
        expect_counts("T6 rerun", 22, 10, 1);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
